literal_exec_core: RTL
======================

# literal_exec_core

Instruction fetch-and-execute core for the immediate-addressing datapath. Drives the 11-bit program ROM address and reads back 14-bit instruction words. Decodes literal (immediate) ALU instructions and GOTO, and maintains the W register and the Z/C/DC status flags. Sits between the program ROM and downstream register/IO logic, which observes `w_out` and the flags.

## Interface
- No parameters. Widths are fixed by the ROM: 11-bit address, 14-bit instruction.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable. When low, all state holds.
- `rom_addr_out` out 11: program address to ROM. Registered; always equals the PC.
- `rom_data_in` in 14: instruction word from the ROM. Combinational, valid in the same cycle.
- `w_out` out 8: W register.
- `z_out` / `c_out` / `dc_out` out 1 each: status flags.
- `instr_done` out 1: one-cycle pulse; an instruction retired at the previous edge.
- `illegal` out 1: one-cycle pulse, coincident with `instr_done`; the retired word was unsupported.

## Operation
- FSM has two states.
  - FETCH: `rom_addr_out` = PC. At the edge, IR <= `rom_data_in`, then go to EXEC.
  - EXEC: decode IR. At the edge, update W, flags and PC, then go to FETCH.
- Each instruction takes 2 cycles.
- Decode on IR[13:8]; k = IR[7:0].
  - 0x30–0x33 MOVLW: W=k. Flags unchanged.
  - 0x34–0x37 RETLW: treated as MOVLW. There is no stack.
  - 0x38 IORLW: W=W|k. Z updated.
  - 0x39 ANDLW: W=W&k. Z updated.
  - 0x3A XORLW: W=W^k. Z updated.
  - 0x3C–0x3D SUBLW: W=k−W (8-bit wrap). Z updated. C=1 iff k≥W (no borrow). DC=1 iff k[3:0]≥W[3:0].
  - 0x3E–0x3F ADDLW: W=W+k (8-bit wrap). Z updated. C=carry out of bit 7. DC=carry out of bit 3.
  - IR[13:11]=3'b101 GOTO: PC=IR[10:0]. W and flags unchanged.
  - IR=0x0000 NOP: no effect.
  - Any other word: executes as NOP, and `illegal` pulses.
- PC update in EXEC: PC+1 modulo 2^11 (0x7FF wraps to 0x000), except for GOTO.
- Z = (result == 0) for every Z-updating instruction.

## Timing
- Reset values:
  - state FETCH
  - PC/`rom_addr_out`=0x000
  - IR=0x0000
  - W=0x00
  - Z=C=DC=0
  - `instr_done`=`illegal`=0
- Reset has priority over `en` and takes effect at any point in the cycle, including mid-EXEC. The instruction in progress is discarded with no partial W/flag update.
- `en`=0: state, PC, IR, W and flags all hold. `instr_done`/`illegal` are 0 in the next cycle. Resuming continues exactly where execution stopped.
- An EXEC edge with `en`=1 updates W/flags/PC. In the following cycle `instr_done`=1 and the new values are visible.
- First instruction after reset release: its address 0x000 is presented in cycle 0, it is latched at the end of cycle 0, and `instr_done` is high in cycle 2.
- `rom_data_in` is sampled only at the FETCH edge. The value during EXEC is ignored.

## Test plan
- Program 0x000–0x006 = 3044, 3E01, 3802, 39FE, 3C47, 3A55, 3AAA, run 14 cycles:
  - W after each retire is 44, 45, 47, 46, 01, 54, FE.
  - After SUBLW: C=1, DC=1, Z=0.
  - Final Z=0, PC=0x007.
- 3000 (MOVLW 0x00) then 3FFF-style ADDLW: MOVLW FF then ADDLW 01 -> W=00, Z=1, C=1, DC=1. Then SUBLW 00 with W=01 -> W=FF, C=0, DC=0, Z=0.
- GOTO 0x2A5 (word 0x2AA5) at 0x000 -> `rom_addr_out`=0x2A5 in the next FETCH; W and flags unchanged.
- PC forced to 0x7FF via GOTO 0x7FF, with a NOP at 0x7FF -> next FETCH address is 0x000.
- Hold `en` low for 5 cycles during EXEC of ADDLW 01 -> no change and no `instr_done`. After `en` rises, the ADDLW retires once with W incremented by exactly 1.
- Two edge cases:
  - Unsupported word 0x0100 -> W and flags unchanged, `illegal`=`instr_done`=1 for one cycle, PC+1.
  - Assert `rst` during EXEC of MOVLW 55 -> W=00 and PC=0x000 after the edge, and `instr_done` stays 0.

Source files
------------

// File: rtl/literal_exec_core.sv
// Two-state fetch/execute core for literal ALU instructions and GOTO.
// Maintains the W register and Z/C/DC flags; the PC drives the ROM address directly.
`default_nettype none

module literal_exec_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [13:0] rom_data_in,
    output logic [10:0] rom_addr_out,
    output logic [7:0]  w_out,
    output logic        z_out,
    output logic        c_out,
    output logic        dc_out,
    output logic        instr_done,
    output logic        illegal
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [10:0] pc;
    logic [10:0] pc_next;
    logic [13:0] ir;
    logic [7:0]  w;
    logic [7:0]  w_next;
    logic        z;
    logic        c;
    logic        dc;
    logic        z_next;
    logic        c_next;
    logic        dc_next;
    logic        ill_next;

    logic [7:0]  k;
    logic [5:0]  op;
    logic [8:0]  sum;
    logic [4:0]  half_sum;
    logic [7:0]  diff;

    assign k        = ir[7:0];
    assign op       = ir[13:8];
    assign sum      = {1'b0, w} + {1'b0, k};
    assign half_sum = {1'b0, w[3:0]} + {1'b0, k[3:0]};
    assign diff     = k - w;

    always_comb begin
        state_next = (state == FETCH) ? EXEC : FETCH;
        pc_next    = pc + 11'd1;
        w_next     = w;
        z_next     = z;
        c_next     = c;
        dc_next    = dc;
        ill_next   = 1'b0;

        if (ir[13:11] == 3'b101) begin
            pc_next = ir[10:0];
        end else if (ir[13:11] == 3'b110) begin
            // MOVLW and RETLW alike: no return stack exists
            w_next = k;
        end else begin
            case (op)
                6'h38: begin
                    w_next = w | k;
                    z_next = ((w | k) == 8'h00);
                end
                6'h39: begin
                    w_next = w & k;
                    z_next = ((w & k) == 8'h00);
                end
                6'h3A: begin
                    w_next = w ^ k;
                    z_next = ((w ^ k) == 8'h00);
                end
                6'h3C, 6'h3D: begin
                    w_next  = diff;
                    z_next  = (diff == 8'h00);
                    c_next  = (k >= w);
                    dc_next = (k[3:0] >= w[3:0]);
                end
                6'h3E, 6'h3F: begin
                    w_next  = sum[7:0];
                    z_next  = (sum[7:0] == 8'h00);
                    c_next  = sum[8];
                    dc_next = half_sum[4];
                end
                default: begin
                    ill_next = (ir != 14'h0000);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= 11'h000;
            ir         <= 14'h0000;
            w          <= 8'h00;
            z          <= 1'b0;
            c          <= 1'b0;
            dc         <= 1'b0;
            instr_done <= 1'b0;
            illegal    <= 1'b0;
        end else if (en) begin
            state <= state_next;
            if (state == FETCH) begin
                ir         <= rom_data_in;
                instr_done <= 1'b0;
                illegal    <= 1'b0;
            end else begin
                pc         <= pc_next;
                w          <= w_next;
                z          <= z_next;
                c          <= c_next;
                dc         <= dc_next;
                instr_done <= 1'b1;
                illegal    <= ill_next;
            end
        end else begin
            instr_done <= 1'b0;
            illegal    <= 1'b0;
        end
    end

    assign rom_addr_out = pc;
    assign w_out        = w;
    assign z_out        = z;
    assign c_out        = c;
    assign dc_out       = dc;

endmodule

`default_nettype wire
